// File: rtl/uart_ram_dumper.sv
// uart_ram_dumper: reads a contiguous RAM word range and streams it LSB-byte-first over the UART TX byte interface.
// Latency: start at E0, RAM read E0-E1, first byte valid from E2; BYTES+2 cycles per word with ready held high.
// Backpressure: uart_tx_ready low stalls SEND/CKSUM with data and valid held; each stalled cycle adds one cycle.
// Build option: define UART_DUMP_CKSUM_EN to append an 8-bit modulo-256 sum of the data bytes after the last word.

module uart_ram_dumper #(
   parameter int ADDR_LEN = 14,
   parameter int XLEN     = 32
) (
   input  logic                clk,
   input  logic                rstb,
   input  logic                dump_start,
   input  logic [ADDR_LEN-1:0] dump_addr,
   input  logic [ADDR_LEN:0]   dump_len,
   output logic                dump_busy,
   output logic                dump_done,
   output logic                ram_rd_en,
   output logic [ADDR_LEN-1:0] ram_addr,
   input  logic [XLEN-1:0]     ram_rd_data,
   output logic                uart_tx_valid,
   output logic [7:0]          uart_tx_data,
   input  logic                uart_tx_ready
);

   localparam int BYTES = XLEN / 8;
   localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_WAIT  = 3'd2,
      S_SEND  = 3'd3,
`ifdef UART_DUMP_CKSUM_EN
      S_CKSUM = 3'd4,
`endif
      S_DONE  = 3'd5
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [ADDR_LEN-1:0] cur_addr;
   logic [ADDR_LEN:0]   remaining;
   logic [IDX_W-1:0]    byte_idx;
   logic [XLEN-1:0]     shreg;
   logic                tx_hs;
   logic                last_byte;
   logic                last_word;
`ifdef UART_DUMP_CKSUM_EN
   logic [7:0]          cksum;
`endif

   // A byte leaves on a valid&ready edge; the last byte of a word closes that word.
   assign tx_hs     = uart_tx_valid & uart_tx_ready;
   assign last_byte = (byte_idx == IDX_W'(BYTES - 1));
   assign last_word = (remaining == (ADDR_LEN + 1)'(1));

   // State register.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and state-decoded outputs; no input reaches an output combinationally.
   always_comb begin
      state_nxt     = state;
      dump_busy     = (state != S_IDLE);
      dump_done     = 1'b0;
      ram_rd_en     = 1'b0;
      ram_addr      = cur_addr;
      uart_tx_valid = 1'b0;
      uart_tx_data  = shreg[7:0];
      case (state)
         S_IDLE: begin
            if (dump_start) begin
               state_nxt = (dump_len == '0) ? S_DONE : S_READ;
            end
         end
         S_READ: begin
            ram_rd_en = 1'b1;
            state_nxt = S_WAIT;
         end
         S_WAIT: begin
            state_nxt = S_SEND;
         end
         S_SEND: begin
            uart_tx_valid = 1'b1;
            if (tx_hs && last_byte) begin
               if (last_word) begin
`ifdef UART_DUMP_CKSUM_EN
                  state_nxt = S_CKSUM;
`else
                  state_nxt = S_DONE;
`endif
               end else begin
                  state_nxt = S_READ;
               end
            end
         end
`ifdef UART_DUMP_CKSUM_EN
         S_CKSUM: begin
            uart_tx_valid = 1'b1;
            uart_tx_data  = cksum;
            if (tx_hs) begin
               state_nxt = S_DONE;
            end
         end
`endif
         S_DONE: begin
            dump_done = 1'b1;
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Address/length counters, byte shifter and running sum.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         cur_addr  <= '0;
         remaining <= '0;
         byte_idx  <= '0;
         shreg     <= '0;
`ifdef UART_DUMP_CKSUM_EN
         cksum     <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (dump_start) begin
                  cur_addr  <= dump_addr;
                  remaining <= dump_len;
                  byte_idx  <= '0;
`ifdef UART_DUMP_CKSUM_EN
                  cksum     <= '0;
`endif
               end
            end
            S_WAIT: begin
               shreg    <= ram_rd_data;
               byte_idx <= '0;
            end
            S_SEND: begin
               if (tx_hs) begin
                  shreg <= shreg >> 8;
`ifdef UART_DUMP_CKSUM_EN
                  cksum <= cksum + shreg[7:0];
`endif
                  if (last_byte) begin
                     byte_idx  <= '0;
                     cur_addr  <= cur_addr + ADDR_LEN'(1);
                     remaining <= remaining - (ADDR_LEN + 1)'(1);
                  end else begin
                     byte_idx <= byte_idx + IDX_W'(1);
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_ram_dumper.sv
// Directed bench for uart_ram_dumper: fixed RAM contents, hand-computed byte streams and cycle offsets.
// Honours UART_DUMP_CKSUM_EN by appending the expected checksum byte and one extra cycle.
// Observes DUT outputs on the falling edge; drives inputs 1 time unit after the rising edge.

module tb_uart_ram_dumper;

   logic        clk;
   logic        rstb;
   logic        dump_start;
   logic [13:0] dump_addr;
   logic [14:0] dump_len;
   logic        dump_busy;
   logic        dump_done;
   logic        ram_rd_en;
   logic [13:0] ram_addr;
   logic [31:0] ram_rd_data;
   logic        uart_tx_valid;
   logic [7:0]  uart_tx_data;
   logic        uart_tx_ready;

   logic [31:0] mem [0:16383];

   int          n_checks;
   int          n_errors;
   int          cyc;
   int          n_valid;
   int          n_stall;
   int          stab_err;
   logic        prev_stall;
   logic [7:0]  prev_data;
   logic [7:0]  tx_q[$];
   logic [13:0] rd_q[$];
   int          done_q[$];

`ifdef UART_DUMP_CKSUM_EN
   localparam int CK = 1;
`else
   localparam int CK = 0;
`endif

   uart_ram_dumper dut (
      .clk           (clk),
      .rstb          (rstb),
      .dump_start    (dump_start),
      .dump_addr     (dump_addr),
      .dump_len      (dump_len),
      .dump_busy     (dump_busy),
      .dump_done     (dump_done),
      .ram_rd_en     (ram_rd_en),
      .ram_addr      (ram_addr),
      .ram_rd_data   (ram_rd_data),
      .uart_tx_valid (uart_tx_valid),
      .uart_tx_data  (uart_tx_data),
      .uart_tx_ready (uart_tx_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous-read RAM model: data appears the cycle after the strobe.
   always @(posedge clk) begin
      if (ram_rd_en) ram_rd_data <= mem[ram_addr];
   end

   // Falling-edge monitor: accepted bytes, read addresses, done pulses and hold-while-stalled.
   always @(negedge clk) begin
      if (rstb) begin
         if (uart_tx_valid && uart_tx_ready) tx_q.push_back(uart_tx_data);
         if (uart_tx_valid) n_valid++;
         if (uart_tx_valid && !uart_tx_ready) n_stall++;
         if (ram_rd_en) rd_q.push_back(ram_addr);
         if (dump_done) done_q.push_back(cyc);
         if (prev_stall && !(uart_tx_valid && uart_tx_data == prev_data)) stab_err++;
         prev_stall = uart_tx_valid && !uart_tx_ready;
         prev_data  = uart_tx_data;
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_bytes(input string tag, input logic [7:0] exp[$]);
      check({tag, "_count"}, 64'(tx_q.size()), 64'(exp.size()));
      for (int i = 0; i < exp.size() && i < tx_q.size(); i++) begin
         check($sformatf("%s_byte%0d", tag, i), 64'(tx_q[i]), 64'(exp[i]));
      end
   endtask

   task automatic start_dump(input logic [13:0] a, input logic [14:0] l, output int c0);
      tx_q.delete();
      rd_q.delete();
      done_q.delete();
      n_valid  = 0;
      n_stall  = 0;
      stab_err = 0;
      @(posedge clk); #1;
      dump_addr  = a;
      dump_len   = l;
      dump_start = 1'b1;
      @(posedge clk); #1;
      c0         = cyc;
      dump_start = 1'b0;
   endtask

   task automatic wait_idle(input bit rnd);
      bit timed_out;
      timed_out = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         uart_tx_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
         @(negedge clk);
         if (!dump_busy) begin
            timed_out = 1'b0;
            break;
         end
         @(posedge clk); #1;
      end
      check("wait_idle_timeout", 64'(timed_out), 64'd0);
   endtask

   initial begin
      logic [7:0] exp_a[$];
      logic [7:0] exp_w[$];
      logic [7:0] exp_r[$];
      int         c0;

      n_checks      = 0;
      n_errors      = 0;
      cyc           = 0;
      n_valid       = 0;
      n_stall       = 0;
      stab_err      = 0;
      prev_stall    = 1'b0;
      prev_data     = 8'h00;
      rstb          = 1'b0;
      dump_start    = 1'b0;
      dump_addr     = '0;
      dump_len      = '0;
      uart_tx_ready = 1'b1;
      ram_rd_data   = '0;
      for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
      mem[14'h0010] = 32'h44332211;
      mem[14'h0011] = 32'h88776655;
      mem[14'h0020] = 32'hEEEEEEEE;
      mem[14'h3FFF] = 32'hDDCCBBAA;
      mem[14'h0000] = 32'h04030201;

      exp_a = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      exp_w = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01, 8'h02, 8'h03, 8'h04};
      exp_r = '{8'h11, 8'h22, 8'h33, 8'h44};
`ifdef UART_DUMP_CKSUM_EN
      exp_a.push_back(8'h64);
      exp_w.push_back(8'h18);
      exp_r.push_back(8'hAA);
`endif

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy",  64'(dump_busy),     64'd0);
      check("rst_done",  64'(dump_done),     64'd0);
      check("rst_rd_en", 64'(ram_rd_en),     64'd0);
      check("rst_addr",  64'(ram_addr),      64'd0);
      check("rst_valid", 64'(uart_tx_valid), 64'd0);
      check("rst_data",  64'(uart_tx_data),  64'd0);
      @(posedge clk); #1;
      rstb = 1'b1;

      // Two words, ready held high
      uart_tx_ready = 1'b1;
      start_dump(14'h0010, 15'd2, c0);
      wait_idle(1'b0);
      check_bytes("basic", exp_a);
      check("basic_rd_count", 64'(rd_q.size()), 64'd2);
      if (rd_q.size() == 2) begin
         check("basic_rd_addr0", 64'(rd_q[0]), 64'h10);
         check("basic_rd_addr1", 64'(rd_q[1]), 64'h11);
      end
      check("basic_done_count", 64'(done_q.size()), 64'd1);
      if (done_q.size() >= 1) check("basic_done_cycle", 64'(done_q[0] - c0), 64'(12 + CK));

      // Same dump under random backpressure
      start_dump(14'h0010, 15'd2, c0);
      wait_idle(1'b1);
      check_bytes("bp", exp_a);
      check("bp_stable", 64'(stab_err), 64'd0);
      check("bp_done_count", 64'(done_q.size()), 64'd1);
      if (done_q.size() >= 1) check("bp_done_cycle", 64'(done_q[0] - c0), 64'(12 + CK + n_stall));

      // Address wrap at the top of RAM
      start_dump(14'h3FFF, 15'd2, c0);
      wait_idle(1'b0);
      check_bytes("wrap", exp_w);
      check("wrap_rd_count", 64'(rd_q.size()), 64'd2);
      if (rd_q.size() == 2) begin
         check("wrap_rd_addr0", 64'(rd_q[0]), 64'h3FFF);
         check("wrap_rd_addr1", 64'(rd_q[1]), 64'h0000);
      end

      // Zero-length dump
      start_dump(14'h0010, 15'd0, c0);
      wait_idle(1'b0);
      check("len0_done_count", 64'(done_q.size()), 64'd1);
      if (done_q.size() >= 1) check("len0_done_cycle", 64'(done_q[0] - c0), 64'd0);
      check("len0_rd_count", 64'(rd_q.size()), 64'd0);
      check("len0_valid_cycles", 64'(n_valid), 64'd0);

      // Start pulse while busy is ignored
      uart_tx_ready = 1'b1;
      start_dump(14'h0010, 15'd2, c0);
      repeat (3) @(posedge clk);
      #1;
      dump_addr  = 14'h0020;
      dump_len   = 15'd1;
      dump_start = 1'b1;
      @(posedge clk); #1;
      dump_start = 1'b0;
      wait_idle(1'b0);
      check_bytes("busy_start", exp_a);
      check("busy_start_rd_count", 64'(rd_q.size()), 64'd2);
      if (rd_q.size() == 2) check("busy_start_rd_addr1", 64'(rd_q[1]), 64'h11);

      // Reset in the middle of a stalled word
      uart_tx_ready = 1'b0;
      start_dump(14'h0010, 15'd2, c0);
      repeat (3) @(posedge clk);
      #1;
      check("mid_valid_before_rst", 64'(uart_tx_valid), 64'd1);
      rstb = 1'b0;
      @(negedge clk);
      check("mid_rst_busy",  64'(dump_busy),     64'd0);
      check("mid_rst_valid", 64'(uart_tx_valid), 64'd0);
      check("mid_rst_data",  64'(uart_tx_data),  64'd0);
      check("mid_rst_rd_en", 64'(ram_rd_en),     64'd0);
      check("mid_rst_addr",  64'(ram_addr),      64'd0);
      check("mid_rst_done",  64'(dump_done),     64'd0);
      check("mid_rst_no_done_pulse", 64'(done_q.size()), 64'd0);
      @(posedge clk); #1;
      rstb = 1'b1;
      start_dump(14'h0010, 15'd1, c0);
      wait_idle(1'b0);
      check_bytes("after_rst", exp_r);
      check("after_rst_done_count", 64'(done_q.size()), 64'd1);
      if (done_q.size() >= 1) check("after_rst_done_cycle", 64'(done_q[0] - c0), 64'(6 + CK));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
